// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        ERR
    } state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } size_e;

    // Size encoding 2'b11 is reserved and always rejected.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return addr_lo[0];
            SZ_W:    return |addr_lo;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering between a right-justified requester view and the
// 32-bit memory word: store strobes/replication and load right-justification.
module dmem_lane_align
    import dmem_arb_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_mem_rdata,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        o_wstrb = 4'b0000;
        o_wdata = i_wdata;
        case (i_size)
            SZ_B: begin
                o_wstrb = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
            end
            SZ_H: begin
                o_wstrb = 4'b0011 << i_addr_lo;
                o_wdata = {2{i_wdata[15:0]}};
            end
            SZ_W: begin
                o_wstrb = 4'b1111;
            end
            default: ;
        endcase
    end

    // Upper bits are left unmasked; the load unit does the extension.
    assign o_rdata = i_mem_rdata >> {i_addr_lo, 3'b000};

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter (port 0 = LSU, port 1 = debug DMA) with a
// starvation guard for port 1. Define DMEM_ARB_PERF_EN to add perf counters.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              p0_req,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic              p0_wen,
    input  logic [1:0]        p0_size,
    input  logic [31:0]       p0_wdata,
    output logic              p0_ack,
    output logic              p0_rvalid,
    output logic [31:0]       p0_rdata,
    output logic              p0_err,
    input  logic              p1_req,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic              p1_wen,
    input  logic [1:0]        p1_size,
    input  logic [31:0]       p1_wdata,
    output logic              p1_ack,
    output logic              p1_rvalid,
    output logic [31:0]       p1_rdata,
    output logic              p1_err,
`ifdef DMEM_ARB_PERF_EN
    output logic [31:0]       perf_grant0,
    output logic [31:0]       perf_grant1,
    output logic [31:0]       perf_stall,
`endif
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    state_e            r_state;
    logic              r_port;
    logic [ADDR_W-1:0] r_addr;
    logic              r_wen;
    logic [1:0]        r_size;
    logic [31:0]       r_wdata;
    logic [7:0]        r_starve;
    logic [1:0]        r_rvalid;
    logic              r_err;
    logic [31:0]       r_rdata;

    logic              w_idle;
    logic              w_any;
    logic              w_grant0;
    logic              w_grant1;
    logic [ADDR_W-1:0] w_sel_addr;
    logic              w_sel_wen;
    logic [1:0]        w_sel_size;
    logic [31:0]       w_sel_wdata;
    logic [3:0]        w_wstrb;
    logic [31:0]       w_lane_wdata;
    logic [31:0]       w_lane_rdata;

    // Port 1 wins when alone or once port 0 has starved it LIMIT times.
    assign w_idle   = (r_state == IDLE) && !reset;
    assign w_any    = p0_req | p1_req;
    assign w_grant1 = p1_req && (!p0_req || (r_starve >= LIMIT));
    assign w_grant0 = p0_req && !w_grant1;
    assign p0_ack   = w_idle && w_grant0;
    assign p1_ack   = w_idle && w_grant1;

    assign w_sel_addr  = w_grant1 ? p1_addr  : p0_addr;
    assign w_sel_wen   = w_grant1 ? p1_wen   : p0_wen;
    assign w_sel_size  = w_grant1 ? p1_size  : p0_size;
    assign w_sel_wdata = w_grant1 ? p1_wdata : p0_wdata;

    dmem_lane_align u_lane (
        .i_size      (r_size),
        .i_addr_lo   (r_addr[1:0]),
        .i_wdata     (r_wdata),
        .i_mem_rdata (mem_rdata),
        .o_wstrb     (w_wstrb),
        .o_wdata     (w_lane_wdata),
        .o_rdata     (w_lane_rdata)
    );

    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            r_state  <= IDLE;
            r_port   <= 1'b0;
            r_addr   <= '0;
            r_wen    <= 1'b0;
            r_size   <= 2'b00;
            r_wdata  <= '0;
            r_starve <= '0;
            r_rvalid <= 2'b00;
            r_err    <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= 2'b00;
            r_err    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_port  <= w_grant1;
                        r_addr  <= w_sel_addr;
                        r_wen   <= w_sel_wen;
                        r_size  <= w_sel_size;
                        r_wdata <= w_sel_wdata;
                        r_state <= misaligned(w_sel_size, w_sel_addr[1:0]) ? ERR : ISSUE;
                    end
                    // p1_req high without a port-1 grant means port 0 won over it.
                    if (w_grant1 || !p1_req) begin
                        r_starve <= '0;
                    end else if (r_starve < LIMIT) begin
                        r_starve <= r_starve + 8'd1;
                    end
                end
                ISSUE: begin
                    if (mem_gnt) begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        r_rdata          <= w_lane_rdata;
                        r_rvalid[r_port] <= 1'b1;
                        r_state          <= IDLE;
                    end
                end
                ERR: begin
                    r_rdata          <= '0;
                    r_err            <= 1'b1;
                    r_rvalid[r_port] <= 1'b1;
                    r_state          <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mem_req   = (r_state == ISSUE);
    assign mem_addr  = {r_addr[ADDR_W-1:2], 2'b00};
    assign mem_we    = mem_req && r_wen;
    assign mem_wstrb = mem_we ? w_wstrb : 4'b0000;
    assign mem_wdata = mem_req ? w_lane_wdata : 32'h0;

    assign p0_rvalid = r_rvalid[0];
    assign p1_rvalid = r_rvalid[1];
    assign p0_err    = r_err && r_rvalid[0];
    assign p1_err    = r_err && r_rvalid[1];
    assign p0_rdata  = r_rvalid[0] ? r_rdata : 32'h0;
    assign p1_rdata  = r_rvalid[1] ? r_rdata : 32'h0;

`ifdef DMEM_ARB_PERF_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_grant0 <= '0;
            perf_grant1 <= '0;
            perf_stall  <= '0;
        end else begin
            if (p0_ack && (perf_grant0 != '1)) perf_grant0 <= perf_grant0 + 32'd1;
            if (p1_ack && (perf_grant1 != '1)) perf_grant1 <= perf_grant1 + 32'd1;
            if (mem_req && !mem_gnt && (perf_stall != '1)) perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized
// single-port transactions checked against a byte-level reference model.
module tb_dmem_arbiter;

    localparam int ADDR_W       = 32;
    localparam int STARVE_LIMIT = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        p0_req, p0_wen, p1_req, p1_wen;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic [1:0]  p0_size, p1_size;
    logic        p0_ack, p0_rvalid, p0_err, p1_ack, p1_rvalid, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perf_grant0, perf_grant1, perf_stall;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    dmem_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clock      (clock),
        .reset      (reset),
        .p0_req     (p0_req),
        .p0_addr    (p0_addr),
        .p0_wen     (p0_wen),
        .p0_size    (p0_size),
        .p0_wdata   (p0_wdata),
        .p0_ack     (p0_ack),
        .p0_rvalid  (p0_rvalid),
        .p0_rdata   (p0_rdata),
        .p0_err     (p0_err),
        .p1_req     (p1_req),
        .p1_addr    (p1_addr),
        .p1_wen     (p1_wen),
        .p1_size    (p1_size),
        .p1_wdata   (p1_wdata),
        .p1_ack     (p1_ack),
        .p1_rvalid  (p1_rvalid),
        .p1_rdata   (p1_rdata),
        .p1_err     (p1_err),
`ifdef DMEM_ARB_PERF_EN
        .perf_grant0(perf_grant0),
        .perf_grant1(perf_grant1),
        .perf_stall (perf_stall),
`endif
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wstrb  (mem_wstrb),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference model: byte-level view of an access.
    function automatic int nbytes(input logic [1:0] size);
        case (size)
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic m_misaligned(input logic [1:0] size, input logic [31:0] addr);
        if (size == 2'b11) return 1'b1;
        return (int'(addr[1:0]) % nbytes(size)) != 0;
    endfunction

    function automatic logic [3:0] m_strb(input logic [1:0] size, input logic [31:0] addr, input logic wen);
        int n;
        int off;
        logic [3:0] r;
        r = 4'b0000;
        if (!wen) return r;
        n   = nbytes(size);
        off = int'(addr[1:0]);
        for (int i = 0; i < 4; i++) begin
            if (i >= off && i < off + n) r[i] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] d);
        int n;
        logic [31:0] r;
        n = nbytes(size);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_rdata(input logic [31:0] raw, input logic [31:0] addr);
        return raw >> (8 * int'(addr[1:0]));
    endfunction

    function automatic logic ack_of(input int port);
        return (port == 0) ? p0_ack : p1_ack;
    endfunction

    function automatic logic rvalid_of(input int port);
        return (port == 0) ? p0_rvalid : p1_rvalid;
    endfunction

    function automatic logic err_of(input int port);
        return (port == 0) ? p0_err : p1_err;
    endfunction

    function automatic logic [31:0] rdata_of(input int port);
        return (port == 0) ? p0_rdata : p1_rdata;
    endfunction

    task automatic drive_port(input int port, input logic req, input logic [31:0] addr,
                              input logic wen, input logic [1:0] size, input logic [31:0] wdata);
        if (port == 0) begin
            p0_req = req; p0_addr = addr; p0_wen = wen; p0_size = size; p0_wdata = wdata;
        end else begin
            p1_req = req; p1_addr = addr; p1_wen = wen; p1_size = size; p1_wdata = wdata;
        end
    endtask

    // Drop the request and put garbage on the fields to prove they were latched.
    task automatic scramble_port(input int port);
        drive_port(port, 1'b0, $urandom, 1'($urandom), 2'($urandom), $urandom);
    endtask

    // One transaction from a single port starting in IDLE; the other port stays idle.
    task automatic run_txn(input string tag, input int port, input logic [31:0] addr,
                           input logic wen, input logic [1:0] size, input logic [31:0] wdata,
                           input logic [31:0] raw, input int gnt_wait, input int rv_wait);
        int          other;
        logic        bad;
        logic [3:0]  e_strb;
        logic [31:0] e_wdata;
        logic [31:0] e_addr;
        logic [31:0] e_rdata;
        other   = 1 - port;
        bad     = m_misaligned(size, addr);
        e_strb  = m_strb(size, addr, wen);
        e_wdata = m_wdata(size, wdata);
        e_addr  = addr - (addr % 4);
        e_rdata = m_rdata(raw, addr);

        drive_port(port, 1'b1, addr, wen, size, wdata);
        #1;
        check({tag, " ack"}, 32'(ack_of(port)), 32'd1);
        check({tag, " other ack"}, 32'(ack_of(other)), 32'd0);
        tick();
        scramble_port(port);
        #1;
        if (bad) begin
            check({tag, " err no mem_req"}, 32'(mem_req), 32'd0);
            check({tag, " err early rvalid"}, 32'(rvalid_of(port)), 32'd0);
            tick();
            check({tag, " err mem_req"}, 32'(mem_req), 32'd0);
            check({tag, " err rvalid"}, 32'(rvalid_of(port)), 32'd1);
            check({tag, " err flag"}, 32'(err_of(port)), 32'd1);
            check({tag, " err rdata"}, rdata_of(port), 32'd0);
        end else begin
            for (int i = 0; i <= gnt_wait; i++) begin
                mem_gnt    = (i == gnt_wait);
                mem_rvalid = (i < gnt_wait);
                mem_rdata  = $urandom;
                check({tag, " mem_req"}, 32'(mem_req), 32'd1);
                check({tag, " mem_addr"}, mem_addr, e_addr);
                check({tag, " mem_we"}, 32'(mem_we), 32'(wen));
                check({tag, " mem_wstrb"}, 32'(mem_wstrb), 32'(e_strb));
                if (wen) check({tag, " mem_wdata"}, mem_wdata, e_wdata);
                check({tag, " issue rvalid"}, 32'(rvalid_of(port)), 32'd0);
                tick();
            end
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            for (int i = 0; i < rv_wait; i++) begin
                check({tag, " wait mem_req"}, 32'(mem_req), 32'd0);
                check({tag, " wait rvalid"}, 32'(rvalid_of(port)), 32'd0);
                tick();
            end
            mem_rvalid = 1'b1;
            mem_rdata  = raw;
            check({tag, " pre rvalid"}, 32'(rvalid_of(port)), 32'd0);
            tick();
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            check({tag, " rvalid"}, 32'(rvalid_of(port)), 32'd1);
            check({tag, " err"}, 32'(err_of(port)), 32'd0);
            if (!wen) check({tag, " rdata"}, rdata_of(port), e_rdata);
        end
        check({tag, " other rvalid"}, 32'(rvalid_of(other)), 32'd0);
        tick();
        check({tag, " rvalid pulse"}, 32'(rvalid_of(port)), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          waited;
        logic        exp_p1;
        int          port;
        logic [31:0] stall0;

        reset = 1'b1;
        drive_port(0, 1'b0, 32'h0, 1'b0, 2'b00, 32'h0);
        drive_port(1, 1'b0, 32'h0, 1'b0, 2'b00, 32'h0);
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        repeat (3) tick();

        check("reset mem_req", 32'(mem_req), 32'd0);
        check("reset mem_addr", mem_addr, 32'd0);
        check("reset mem_wstrb", 32'(mem_wstrb), 32'd0);
        check("reset rvalids", 32'({p0_rvalid, p1_rvalid, p0_err, p1_err}), 32'd0);
        reset = 1'b0;
        tick();
        check("post reset acks", 32'({p0_ack, p1_ack}), 32'd0);
        check("post reset rdata", p0_rdata | p1_rdata, 32'd0);
`ifdef DMEM_ARB_PERF_EN
        check("reset perf", perf_grant0 | perf_grant1 | perf_stall, 32'd0);
`endif

        // Byte store at 0x1003: strobe 1000, replicated data, 3-cycle latency.
        run_txn("p0 byte store", 0, 32'h0000_1003, 1'b1, 2'b00, 32'h0000_00AB, 32'h0, 0, 0);
        // Half load at 0x2002 returns the upper half right-justified.
        run_txn("p1 half load", 1, 32'h0000_2002, 1'b0, 2'b01, 32'h0, 32'hBEEF_1234, 0, 0);
        // Misaligned word load: no memory access, error two cycles after ack.
        run_txn("p0 misaligned", 0, 32'h0000_3001, 1'b0, 2'b10, 32'h0, 32'h0, 0, 0);
        // Grant held off for 5 cycles; fields must stay stable.
`ifdef DMEM_ARB_PERF_EN
        stall0 = perf_stall;
`else
        stall0 = 32'h0;
`endif
        run_txn("p1 word stall", 1, 32'h0000_4440, 1'b1, 2'b10, 32'hCAFE_F00D, 32'h0, 5, 2);
`ifdef DMEM_ARB_PERF_EN
        check("perf stall", perf_stall - stall0, 32'd5);
`else
        check("stall base", stall0, 32'h0);
`endif

        // Both ports requesting back to back: every (LIMIT+1)th grant goes to port 1.
        drive_port(0, 1'b1, 32'h0000_0100, 1'b0, 2'b10, 32'h0);
        drive_port(1, 1'b1, 32'h0000_0200, 1'b0, 2'b10, 32'h0);
        #1;
        for (int g = 0; g < 2 * (STARVE_LIMIT + 1) + 2; g++) begin
            waited = 0;
            while (!p0_ack && !p1_ack && waited < 8) begin
                tick();
                waited++;
            end
            exp_p1 = ((g % (STARVE_LIMIT + 1)) == STARVE_LIMIT);
            check("starve ack seen", 32'(p0_ack | p1_ack), 32'd1);
            check("starve winner p1", 32'(p1_ack), 32'(exp_p1));
            check("starve winner p0", 32'(p0_ack), 32'(!exp_p1));
            tick();
            mem_gnt = 1'b1;
            tick();
            mem_gnt = 1'b0;
            mem_rvalid = 1'b1;
            mem_rdata = $urandom;
            tick();
            mem_rvalid = 1'b0;
            check("starve rvalid", 32'({p1_rvalid, p0_rvalid}), exp_p1 ? 32'd2 : 32'd1);
        end
        drive_port(0, 1'b0, 32'h0, 1'b0, 2'b00, 32'h0);
        drive_port(1, 1'b0, 32'h0, 1'b0, 2'b00, 32'h0);
        tick();
        tick();

        // Reset while waiting for the response; the late response must be dropped.
        drive_port(0, 1'b1, 32'h0000_0040, 1'b0, 2'b10, 32'h0);
        #1;
        check("rst txn ack", 32'(p0_ack), 32'd1);
        tick();
        scramble_port(0);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata = 32'h1234_5678;
        check("rst mem_req", 32'(mem_req), 32'd0);
        check("rst no rvalid", 32'({p0_rvalid, p1_rvalid}), 32'd0);
        tick();
        mem_rvalid = 1'b0;
        check("late rsp dropped", 32'({p0_rvalid, p1_rvalid}), 32'd0);
        tick();
        run_txn("post reset txn", 1, 32'h0000_5001, 1'b0, 2'b00, 32'h0, 32'hA1B2_C3D4, 1, 0);

        // Randomized single-port traffic, including reserved size and unaligned addresses.
        for (int k = 0; k < 40; k++) begin
            port = int'($urandom_range(0, 1));
            run_txn("rand", port, $urandom, 1'($urandom), 2'($urandom_range(0, 3)),
                    $urandom, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
